// File: rtl/morty_fetch.sv
// morty_fetch: instruction fetch stage of the Morty RV32 core.
//
// Holds the program counter and issues one instruction-memory request at a
// time. Each fetched word is presented to decode over a valid/ready handshake.
// A redirect discards any in-flight or buffered instruction and restarts
// fetching at the target. Bus errors and misaligned targets produce a single
// fault slot, after which fetch halts until the next redirect.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   redirect_valid, redirect_pc    taken branch/jump pulse and its target
//   imem_req_valid/ready/addr      request channel to instruction memory
//   imem_rsp_valid/data/err        response channel (one per accepted request)
//   if_valid/ready                 handshake towards decode
//   if_pc, if_instr, if_fault      registered slot presented to decode
module morty_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_fault
);

    typedef enum logic [2:0] {StReq, StWait, StHold, StDrain, StHalt} state_e;

    state_e      state_q, state_d;
    // Set while draining an abandoned response on behalf of a misaligned
    // redirect; the fault slot is presented once that response arrives.
    logic        pend_fault_q, pend_fault_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic        buf_fault_q, buf_fault_d;
    logic        misaligned;

    assign misaligned = (redirect_pc[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StReq;
            pend_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_fault_q <= pend_fault_d;
        end
    end

    // Next-state logic; redirect has priority over every other event.
    always_comb begin
        state_d      = state_q;
        pend_fault_d = pend_fault_q;
        if (redirect_valid) begin
            pend_fault_d = 1'b0;
            case (state_q)
                StReq: begin
                    if (imem_req_ready) begin
                        state_d      = StDrain;
                        pend_fault_d = misaligned;
                    end else begin
                        state_d = misaligned ? StHold : StReq;
                    end
                end
                StWait: begin
                    if (imem_rsp_valid) begin
                        state_d = misaligned ? StHold : StReq;
                    end else begin
                        state_d      = StDrain;
                        pend_fault_d = misaligned;
                    end
                end
                StDrain: begin
                    state_d      = StDrain;
                    pend_fault_d = misaligned;
                end
                default: state_d = misaligned ? StHold : StReq;
            endcase
        end else begin
            case (state_q)
                StReq:  if (imem_req_ready) state_d = StWait;
                StWait: if (imem_rsp_valid) state_d = StHold;
                StHold: if (if_ready) state_d = buf_fault_q ? StHalt : StReq;
                StDrain: begin
                    if (imem_rsp_valid) begin
                        state_d      = pend_fault_q ? StHold : StReq;
                        pend_fault_d = 1'b0;
                    end
                end
                StHalt:  state_d = StHalt;
                default: state_d = StReq;
            endcase
        end
    end

    // PC and output buffer next values
    always_comb begin
        pc_d        = pc_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        buf_fault_d = buf_fault_q;
        if (redirect_valid) begin
            pc_d        = redirect_pc;
            buf_instr_d = NOP_INSTR;
            buf_fault_d = 1'b0;
            // Only a misaligned target can enter HOLD directly on a redirect.
            if (state_d == StHold) begin
                buf_pc_d    = redirect_pc;
                buf_fault_d = 1'b1;
            end
        end else begin
            case (state_q)
                StWait: begin
                    if (imem_rsp_valid) begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = imem_rsp_err ? NOP_INSTR : imem_rsp_data;
                        buf_fault_d = imem_rsp_err;
                        pc_d        = pc_q + 32'd4;
                    end
                end
                StHold: begin
                    if (if_ready) begin
                        buf_instr_d = NOP_INSTR;
                        buf_fault_d = 1'b0;
                    end
                end
                StDrain: begin
                    if (imem_rsp_valid && pend_fault_q) begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = NOP_INSTR;
                        buf_fault_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_ADDR;
            buf_pc_q    <= RESET_ADDR;
            buf_instr_q <= NOP_INSTR;
            buf_fault_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_fault_q <= buf_fault_d;
        end
    end

    // Outputs: decoded from registered state only.
    always_comb begin
        imem_req_valid = rst_n && (state_q == StReq);
        imem_req_addr  = pc_q;
        if_valid       = (state_q == StHold);
        if_pc          = buf_pc_q;
        if_instr       = buf_instr_q;
        if_fault       = buf_fault_q;
    end

endmodule

// File: tb/tb_morty_fetch.sv
// Directed bench for morty_fetch. Inputs change and outputs are sampled on
// the falling clock edge; the DUT updates on the rising edge in between.
module tb_morty_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_fault;

    int n_checks = 0;
    int n_errors = 0;

    morty_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_fault       (if_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock with the currently driven inputs, then clear them.
    task automatic tick();
        @(negedge clk);
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        if_ready       = 1'b0;
    endtask

    task automatic do_req(input logic [31:0] addr);
        check("req_valid", imem_req_valid, 1);
        check("req_addr", imem_req_addr, addr);
        imem_req_ready = 1'b1;
        tick();
        check("wait_no_req", imem_req_valid, 0);
    endtask

    task automatic do_rsp(input logic [31:0] data, input logic err);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        imem_rsp_err   = err;
        tick();
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
    endtask

    task automatic check_slot(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic fault);
        check({tag, "_valid"}, if_valid, 1);
        check({tag, "_pc"}, if_pc, pc);
        check({tag, "_instr"}, if_instr, instr);
        check({tag, "_fault"}, if_fault, fault);
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, NOP);
        check("rst_if_fault", if_fault, 0);
        rst_n = 1'b1;
        #1;
        check("rel_req_valid", imem_req_valid, 1);
        check("rel_req_addr", imem_req_addr, 32'h0);
        tick();

        // Sequential fetch: REQ -> WAIT -> HOLD each word
        do_req(32'h0);
        do_rsp(32'h00A0_0093, 1'b0);
        check_slot("seq0", 32'h0, 32'h00A0_0093, 1'b0);
        if_ready = 1'b1;
        tick();
        check("seq0_consumed", if_valid, 0);
        check("seq0_nop", if_instr, NOP);
        do_req(32'h4);
        do_rsp(32'h0010_0113, 1'b0);
        check_slot("seq1", 32'h4, 32'h0010_0113, 1'b0);
        if_ready = 1'b1;
        tick();
        do_req(32'h8);
        do_rsp(32'h0020_0193, 1'b0);
        check_slot("seq2", 32'h8, 32'h0020_0193, 1'b0);

        // Backpressure: slot held stable, no request
        for (int i = 0; i < 5; i++) begin
            tick();
            check_slot("bp", 32'h8, 32'h0020_0193, 1'b0);
            check("bp_no_req", imem_req_valid, 0);
        end
        if_ready = 1'b1;
        tick();
        check("bp_release_valid", if_valid, 0);

        // Redirect while waiting; response arrives 3 cycles later
        do_req(32'hC);
        redirect(32'h100);
        tick();
        check("drain_if_valid", if_valid, 0);
        check("drain_no_req", imem_req_valid, 0);
        tick();
        tick();
        do_rsp(32'hBAD0_0001, 1'b0);
        check("drain_discard", if_valid, 0);
        do_req(32'h100);
        do_rsp(32'h1111_1111, 1'b0);
        check_slot("rdw", 32'h100, 32'h1111_1111, 1'b0);
        if_ready = 1'b1;
        tick();

        // Redirect in the same cycle as a response
        do_req(32'h104);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0002;
        redirect(32'h200);
        tick();
        check("col_rsp_if_valid", if_valid, 0);
        check("col_rsp_instr", if_instr, NOP);

        // Redirect in HOLD together with if_ready
        do_req(32'h200);
        do_rsp(32'h2222_2222, 1'b0);
        check_slot("col_hold", 32'h200, 32'h2222_2222, 1'b0);
        if_ready = 1'b1;
        redirect(32'h200);
        tick();
        check("col_hold_if_valid", if_valid, 0);
        check("col_hold_instr", if_instr, NOP);

        // Redirect in REQ without ready: new address next cycle
        redirect(32'h8);
        tick();

        // Bus error at 0x8, then HALT until redirect
        do_req(32'h8);
        do_rsp(32'hDEAD_BEEF, 1'b1);
        check_slot("err", 32'h8, NOP, 1'b1);
        if_ready = 1'b1;
        tick();
        check("halt_if_valid", if_valid, 0);
        check("halt_if_fault", if_fault, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_no_req", imem_req_valid, 0);
        end
        redirect(32'h40);
        tick();

        // Misaligned redirect from REQ: fault slot, no request
        check("resume_req_valid", imem_req_valid, 1);
        check("resume_req_addr", imem_req_addr, 32'h40);
        redirect(32'h102);
        tick();
        check_slot("mis", 32'h102, NOP, 1'b1);
        check("mis_no_req", imem_req_valid, 0);
        tick();
        check_slot("mis_hold", 32'h102, NOP, 1'b1);
        if_ready = 1'b1;
        tick();
        check("mis_halt_req", imem_req_valid, 0);
        check("mis_halt_valid", if_valid, 0);

        // Misaligned redirect while waiting: drain first, then fault
        redirect(32'h300);
        tick();
        do_req(32'h300);
        redirect(32'h306);
        tick();
        check("mis_drain_valid", if_valid, 0);
        check("mis_drain_req", imem_req_valid, 0);
        do_rsp(32'hBAD0_0003, 1'b0);
        check_slot("mis_drain", 32'h306, NOP, 1'b1);
        if_ready = 1'b1;
        tick();

        // PC wrap
        redirect(32'hFFFF_FFFC);
        tick();
        do_req(32'hFFFF_FFFC);
        do_rsp(32'h3333_3333, 1'b0);
        check_slot("wrap", 32'hFFFF_FFFC, 32'h3333_3333, 1'b0);
        if_ready = 1'b1;
        tick();
        check("wrap_req_valid", imem_req_valid, 1);
        check("wrap_req_addr", imem_req_addr, 32'h0);

        // Reset mid-operation
        do_req(32'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_valid", imem_req_valid, 0);
        check("mid_rst_if_pc", if_pc, 32'h0);
        check("mid_rst_if_valid", if_valid, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rel_req_valid", imem_req_valid, 1);
        check("mid_rel_req_addr", imem_req_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
